reg_select_encoder: RTL



---
 rtl/reg_select_encoder_pkg.sv | 21 ++
 rtl/reg_select_encoder_if.sv | 26 ++
 rtl/onehot_decoder.sv | 11 +
 rtl/reg_select_encoder.sv | 75 +++++++
 4 files changed

// File: rtl/reg_select_encoder_pkg.sv
// sel_enc_pkg: defaults, IR field-offset helpers and the field-select enum for reg_select_encoder.
package sel_enc_pkg;
    localparam int NUM_REGS_D = 16;
    localparam int IR_W_D = 32;
    localparam int OPC_W_D = 5;
    localparam int C_W_D = 19;
    typedef enum logic [2:0] {SEL_NONE, SEL_A, SEL_B, SEL_C, SEL_ERR} sel_e;
    // Ra sits directly below the opcode, Rb below Ra, Rc below Rb
    function automatic int ra_lsb(input int ir_w, input int opc_w, input int idx_w);
        return ir_w - opc_w - idx_w;
    endfunction
    function automatic int rb_lsb(input int ir_w, input int opc_w, input int idx_w);
        return ir_w - opc_w - 2 * idx_w;
    endfunction
    function automatic int rc_lsb(input int ir_w, input int opc_w, input int idx_w);
        return ir_w - opc_w - 3 * idx_w;
    endfunction
    function automatic int c_msb(input int c_w);
        return c_w - 1;
    endfunction
endpackage

// File: rtl/reg_select_encoder_if.sv
// reg_select_encoder_if: sequencer/IR-bus side of reg_select_encoder; master = control unit, slave = encoder.
interface reg_select_encoder_if
    import sel_enc_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int IR_W = IR_W_D,
    parameter int OPC_W = OPC_W_D,
    parameter int C_W = C_W_D
);
    localparam int IDX_W = $clog2(NUM_REGS);
    logic [IR_W-1:0] ir_in;
    logic ir_load, gra, grb, grc, r_in, r_out, ba_out, issue, wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic [OPC_W-1:0] opcode;
    logic [NUM_REGS-1:0] regin, regout;
    logic ba_zero, sel_err, hazard;
    logic [IR_W-1:0] c_sext;
    modport master (
        output ir_in, ir_load, gra, grb, grc, r_in, r_out, ba_out, issue, wb_valid, wb_idx,
        input opcode, regin, regout, ba_zero, sel_err, c_sext, hazard
    );
    modport slave (
        input ir_in, ir_load, gra, grb, grc, r_in, r_out, ba_out, issue, wb_valid, wb_idx,
        output opcode, regin, regout, ba_zero, sel_err, c_sext, hazard
    );
endinterface

// File: rtl/onehot_decoder.sv
// onehot_decoder: binary index to 2**IDX_W one-hot, all zero when en is low.
module onehot_decoder #(
    parameter int IDX_W = 4
) (
    input logic en,
    input logic [IDX_W-1:0] idx,
    output logic [2**IDX_W-1:0] oh
);
    localparam logic [2**IDX_W-1:0] ONE = 1;
    assign oh = en ? ONE << idx : '0;
endmodule

// File: rtl/reg_select_encoder.sv
// reg_select_encoder: IR latch, Ra/Rb/Rc select into registered one-hot regin/regout enables.
// Define SELENC_SCOREBOARD_EN to build the pending-write scoreboard that drives hazard.
module reg_select_encoder
    import sel_enc_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int IR_W = IR_W_D,
    parameter int OPC_W = OPC_W_D,
    parameter int C_W = C_W_D
) (
    input logic clk,
    input logic rst_n,
    reg_select_encoder_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int RA_L = ra_lsb(IR_W, OPC_W, IDX_W);
    localparam int RB_L = rb_lsb(IR_W, OPC_W, IDX_W);
    localparam int RC_L = rc_lsb(IR_W, OPC_W, IDX_W);
    localparam int C_M = c_msb(C_W);
    logic [IR_W-1:0] ir;
    logic [IDX_W-1:0] ra, rb, rc, idx;
    logic [NUM_REGS-1:0] oh, regin, regout;
    logic ba_zero, sel_err, bz, vld, hz;
    sel_e sel;
    assign ra = ir[RA_L +: IDX_W];
    assign rb = ir[RB_L +: IDX_W];
    assign rc = ir[RC_L +: IDX_W];
    always_comb begin
        sel = $countones({bus.gra, bus.grb, bus.grc}) > 1 ? SEL_ERR :
              bus.gra ? SEL_A : bus.grb ? SEL_B : bus.grc ? SEL_C : SEL_NONE;
        idx = sel == SEL_A ? ra : sel == SEL_B ? rb : rc;
        vld = sel inside {SEL_A, SEL_B, SEL_C};
        bz = vld && bus.ba_out && idx == '0;
    end
    onehot_decoder #(.IDX_W(IDX_W)) u_dec (.en(vld), .idx(idx), .oh(oh));
    // decode sees the pre-load IR when ir_load coincides with strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
            regin <= '0;
            regout <= '0;
            ba_zero <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            ir <= bus.ir_load ? bus.ir_in : ir;
            regin <= bus.r_in ? oh : '0;
            regout <= (bus.r_out || bus.ba_out) && !bz ? oh : '0;
            ba_zero <= bz;
            sel_err <= sel == SEL_ERR;
        end
    end
`ifdef SELENC_SCOREBOARD_EN
    localparam logic [NUM_REGS-1:0] ONE = 1;
    logic [NUM_REGS-1:0] pending, set_m, clr_m;
    assign hz = pending[rb] | pending[rc];
    assign set_m = bus.issue && !hz && ra != '0 ? ONE << ra : '0;
    assign clr_m = bus.wb_valid ? ONE << bus.wb_idx : '0;
    // set is OR-ed after the clear so a same-index set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else pending <= (pending & ~clr_m) | set_m;
    end
`else
    logic unused_sb;
    assign unused_sb = ^{bus.issue, bus.wb_valid, bus.wb_idx};
    assign hz = 1'b0;
`endif
    assign bus.opcode = ir[IR_W-1 -: OPC_W];
    assign bus.c_sext = {{(IR_W - C_W){ir[C_M]}}, ir[C_M:0]};
    assign bus.regin = regin;
    assign bus.regout = regout;
    assign bus.ba_zero = ba_zero;
    assign bus.sel_err = sel_err;
    assign bus.hazard = hz;
endmodule
